// File: rtl/pool_job_ctrl.sv
// pool_job_ctrl: one-window job sequencer for the free-running pooling unit.
// Buffers WIN samples, clears the pool, bursts the window, then returns mu.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_mode      job request (mode 0 avg, 1 max)
//   in_valid/in_ready/in_data         sample stream
//   pool_clr_n/pool_mode/pool_data    registered drive into the pool
//   pool_mu                           pool result input
//   res_valid/res_ready/res_data/res_mode  result port
//   busy                              controller not idle
module pool_job_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN        = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  pool_clr_n,
  output logic                  pool_mode,
  output logic [DATA_WIDTH-1:0] pool_data,
  input  logic [DATA_WIDTH-1:0] pool_mu,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_mode,
  output logic                  busy
);

  localparam int CW = $clog2(WIN) + 1;
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] WIN_C = CW'(WIN);
  localparam logic [AW-1:0] A0 = '0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FILL,
    BURST,
    DRAIN,
    RESULT
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          drain_q, drain_d;
  logic          mode_q, mode_d;
  logic          clr_n_q, clr_n_d;
  logic          pmode_q, pmode_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic          rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic          rmode_q, rmode_d;
  logic          cready_q, cready_d;
  logic          busy_q, busy_d;

  logic [DATA_WIDTH-1:0] mem_q [WIN];
  logic                  wr_en;

  assign in_ready = (state_q == FILL);
  assign wr_en    = in_ready & in_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    mode_d   = mode_q;
    clr_n_d  = 1'b1;
    pmode_d  = pmode_q;
    pdata_d  = pdata_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rmode_d  = rmode_q;

    unique case (state_q)
      IDLE: begin
        pmode_d = 1'b1;
        pdata_d = '0;
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          cnt_d   = '0;
          clr_n_d = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        pmode_d = mode_q;
        state_d = FILL;
      end
      FILL: begin
        if (in_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == WIN_C) begin
            // First burst sample must already sit on
            // pool_data during burst cycle 0.
            idx_d   = '0;
            pdata_d = mem_q[A0];
            state_d = BURST;
          end
        end
      end
      BURST: begin
        idx_d = idx_q + CW'(1);
        if (idx_d == WIN_C) begin
          pdata_d = '0;
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          pdata_d = mem_q[idx_d[AW-1:0]];
        end
      end
      DRAIN: begin
        // Two cycles cover the pool's sum->mu
        // register latency.
        drain_d = 1'b1;
        if (drain_q) begin
          rvalid_d = 1'b1;
          rdata_d  = pool_mu;
          rmode_d  = mode_q;
          state_d  = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          rvalid_d = 1'b0;
          pmode_d  = 1'b1;
          pdata_d  = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cready_d = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      mode_q   <= 1'b0;
      clr_n_q  <= 1'b1;
      pmode_q  <= 1'b1;
      pdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rmode_q  <= 1'b0;
      cready_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      mode_q   <= mode_d;
      clr_n_q  <= clr_n_d;
      pmode_q  <= pmode_d;
      pdata_q  <= pdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rmode_q  <= rmode_d;
      cready_q <= cready_d;
      busy_q   <= busy_d;
    end
  end

  // Sample buffer carries no reset; cnt gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q[AW-1:0]] <= in_data;
    end
  end

  assign cmd_ready  = cready_q;
  assign pool_clr_n = clr_n_q;
  assign pool_mode  = pmode_q;
  assign pool_data  = pdata_q;
  assign res_valid  = rvalid_q;
  assign res_data   = rdata_q;
  assign res_mode   = rmode_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pool_job_ctrl.sv
// tb_pool_job_ctrl: directed bench for pool_job_ctrl.
// Includes a behavioural model of the pooling unit driving pool_mu.
module tb_pool_job_ctrl;

  localparam int DW  = 8;
  localparam int WIN = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          pool_clr_n;
  logic          pool_mode;
  logic [DW-1:0] pool_data;
  logic [DW-1:0] pool_mu;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_mode;
  logic          busy;

  always #5 clk = ~clk;

  pool_job_ctrl #(.DATA_WIDTH(DW), .WIN(WIN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .pool_clr_n(pool_clr_n),
    .pool_mode(pool_mode),
    .pool_data(pool_data),
    .pool_mu(pool_mu),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_mode(res_mode),
    .busy(busy)
  );

  // Pool model: sliding-window sum, running max, mu one edge behind.
  wire           pool_rst_n = rst_n & pool_clr_n;
  logic [DW-1:0] ph [WIN];
  int            psum;
  logic [DW-1:0] pmax;
  logic [DW-1:0] pmu;

  always @(posedge clk or negedge pool_rst_n) begin
    if (!pool_rst_n) begin
      for (int i = 0; i < WIN; i++) ph[i] <= '0;
      psum <= 0;
      pmax <= '0;
      pmu  <= '0;
    end else begin
      ph[0] <= pool_data;
      for (int i = 1; i < WIN; i++) ph[i] <= ph[i-1];
      psum <= psum + int'(pool_data) - int'(ph[WIN-1]);
      if (pool_data > pmax) pmax <= pool_data;
      pmu <= pool_mode ? pmax : DW'(psum / WIN);
    end
  end
  assign pool_mu = pmu;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] samp [WIN];

  task automatic fill_samp(input int kind);
    for (int i = 0; i < WIN; i++) begin
      case (kind)
        0: samp[i] = 8'd100;
        1: samp[i] = 8'd200;
        2: samp[i] = (i < 32) ? 8'd0 : 8'd128;
        3: samp[i] = (i < 63) ? 8'd255 : 8'd0;
        4: samp[i] = (i == 0) ? 8'd10 : (i == 1) ? 8'd20 :
                     (i == 2) ? 8'd30 : (i == 3) ? 8'd15 :
                     (i == 4) ? 8'd40 : 8'd0;
        5: samp[i] = 8'd5;
        default: samp[i] = 8'd77;
      endcase
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    chk({p, "_in_ready"}, in_ready, 0);
    chk({p, "_pool_clr_n"}, pool_clr_n, 1);
    chk({p, "_pool_mode"}, pool_mode, 1);
    chk({p, "_pool_data"}, pool_data, 0);
    chk({p, "_res_valid"}, res_valid, 0);
    chk({p, "_res_data"}, res_data, 0);
    chk({p, "_res_mode"}, res_mode, 0);
    chk({p, "_busy"}, busy, 0);
  endtask

  // Returns with the handshake edge just passed; h = its cycle number.
  task automatic start_cmd(input logic m, output int h);
    int t;
    t = 0;
    cmd_mode  = m;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 20) begin
      tick();
      t++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    tick();
    h = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int  i;
    int  t;
    bit  rdy;
    bit  v;
    i = 0;
    t = 0;
    while (i < n && t < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = samp[i];
      rdy = in_ready;
      v   = in_valid;
      tick();
      if (rdy && v) i++;
      t++;
    end
    in_valid = 1'b0;
    if (i < n) chk("feed_timeout", i, n);
  endtask

  // Waits for the result, optionally stalls res_ready for hold cycles
  // with a pending command, then consumes it.
  task automatic wait_res(input int hold, input logic [DW-1:0] exp,
                          input logic exp_m, output logic [DW-1:0] d,
                          output logic m, output int at);
    int t;
    t = 0;
    while (!res_valid && t < 400) begin
      tick();
      t++;
    end
    chk("res_valid_timeout", res_valid, 1);
    at = cyc;
    d  = res_data;
    m  = res_mode;
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_mode  = 1'b0;
      for (int k = 0; k < hold; k++) begin
        chk("hold_cmd_ready", cmd_ready, 0);
        chk("hold_busy", busy, 1);
        tick();
        chk("hold_res_valid", res_valid, 1);
        chk("hold_res_data", res_data, exp);
        chk("hold_res_mode", res_mode, exp_m);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_clear", res_valid, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  typedef struct {
    logic          mode;
    int            kind;
    bit            gaps;
    int            hold;
    bit            lat;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tv [6];

  task automatic set_vec(input int n, input logic mode, input int kind,
                         input bit gaps, input int hold, input bit lat,
                         input logic [DW-1:0] exp);
    tv[n].mode = mode;
    tv[n].kind = kind;
    tv[n].gaps = gaps;
    tv[n].hold = hold;
    tv[n].lat  = lat;
    tv[n].exp  = exp;
  endtask

  task automatic run_job(input logic mode, input bit gaps, input int hold,
                         input bit lat, input logic [DW-1:0] exp);
    int            h;
    int            at;
    logic [DW-1:0] d;
    logic          m;
    start_cmd(mode, h);
    chk("clear_pool_clr_n", pool_clr_n, 0);
    chk("clear_in_ready", in_ready, 0);
    chk("clear_cmd_ready", cmd_ready, 0);
    chk("clear_busy", busy, 1);
    feed(WIN, gaps);
    wait_res(hold, exp, mode, d, m, at);
    chk("res_data", d, exp);
    chk("res_mode", m, mode);
    if (lat) chk("latency", at - h, 131);
  endtask

  initial begin
    int            h;
    int            at;
    logic [DW-1:0] d;
    logic          m;

    set_vec(0, 1'b0, 0, 1'b0, 0,  1'b1, 8'd100);
    set_vec(1, 1'b0, 1, 1'b0, 0,  1'b1, 8'd200);
    set_vec(2, 1'b0, 2, 1'b1, 0,  1'b0, 8'd64);
    set_vec(3, 1'b0, 3, 1'b0, 0,  1'b0, 8'd251);
    set_vec(4, 1'b1, 4, 1'b0, 0,  1'b0, 8'd40);
    set_vec(5, 1'b1, 5, 1'b0, 10, 1'b0, 8'd5);

    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset("por");
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 6; n++) begin
      fill_samp(tv[n].kind);
      run_job(tv[n].mode, tv[n].gaps, tv[n].hold, tv[n].lat, tv[n].exp);
    end

    // Command held pending through the stalled result is taken now.
    tick();
    chk("pend_busy", busy, 1);
    chk("pend_pool_clr_n", pool_clr_n, 0);
    chk("pend_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b0;

    // Reset in FILL after 30 samples.
    feed(30, 1'b0);
    chk("fill_in_ready", in_ready, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_fill");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset in BURST.
    fill_samp(1);
    start_cmd(1'b1, h);
    feed(WIN, 1'b0);
    repeat (10) tick();
    chk("burst_busy", busy, 1);
    chk("burst_in_ready", in_ready, 0);
    chk("burst_pool_data", pool_data, 200);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_burst");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    fill_samp(6);
    start_cmd(1'b0, h);
    feed(WIN, 1'b0);
    wait_res(0, 8'd77, 1'b0, d, m, at);
    chk("post_rst_data", d, 77);
    chk("post_rst_mode", m, 0);
    chk("post_rst_latency", at - h, 131);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
